// File: rtl/pcie_rb_ctrl.sv
// pcie_rb_ctrl: ring-buffer write/read pointer control with enable/drain FSM for the PCIe PDU generator
// Ports: Clk/Rst_n (sync active-low); host_enable, host_rd_ptr(_valid) from software;
// pcie_rb_update_valid/size from the PDU generator; pcie_rb_wr_base_addr, pcie_rb_almost_full and
// disable_pcie back to it; rb_occupancy, update_err (sticky overflow) and pdu_cnt for status.
module pcie_rb_ctrl #(
  parameter int PDU_AWIDTH = 12,
  parameter int AF_MARGIN = 64
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  host_enable,
  input  logic [PDU_AWIDTH-1:0] host_rd_ptr,
  input  logic                  host_rd_ptr_valid,
  input  logic                  pcie_rb_update_valid,
  input  logic [PDU_AWIDTH-1:0] pcie_rb_update_size,
  output logic [PDU_AWIDTH-1:0] pcie_rb_wr_base_addr,
  output logic                  pcie_rb_almost_full,
  output logic                  disable_pcie,
  output logic [PDU_AWIDTH-1:0] rb_occupancy,
  output logic                  update_err,
  output logic [31:0]           pdu_cnt
);
  localparam logic [1:0] DISABLED = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  logic [1:0] state, state_nxt;
  logic [PDU_AWIDTH-1:0] wr_ptr, rd_ptr, occupancy, free;
  logic accept, overflow;
  // One slot is always left empty so full and empty stay distinguishable without a wrap bit.
  assign occupancy = wr_ptr - rd_ptr;
  assign free = {PDU_AWIDTH{1'b1}} - occupancy;
  // Updates are checked against the pre-load rd_ptr, so a same-cycle rd_ptr advance never
  // lets a PDU in that would not have fit before it.
  assign accept = pcie_rb_update_valid && pcie_rb_update_size != '0 && pcie_rb_update_size <= free;
  assign overflow = pcie_rb_update_valid && pcie_rb_update_size > free;
  assign pcie_rb_wr_base_addr = wr_ptr;
  assign rb_occupancy = occupancy;
  assign disable_pcie = state != RUN;
  assign pcie_rb_almost_full = 32'(free) < 32'(AF_MARGIN) || state == DISABLED;
  always_comb
    state_nxt = state == DISABLED ? (host_enable ? RUN : DISABLED) :
                state == RUN      ? (host_enable ? RUN : DRAIN) :
                host_enable       ? RUN :
                (occupancy == '0 && !accept) ? DISABLED : DRAIN;
  always_ff @(posedge Clk)
    if (!Rst_n) begin
      state <= DISABLED;
      wr_ptr <= '0;
      rd_ptr <= '0;
      pdu_cnt <= '0;
      update_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        wr_ptr <= wr_ptr + pcie_rb_update_size;
        pdu_cnt <= pdu_cnt + 32'd1;
      end
      if (host_rd_ptr_valid) rd_ptr <= host_rd_ptr;
      if (overflow) update_err <= 1'b1;
    end
endmodule

// File: tb/tb_pcie_rb_ctrl.sv
// tb_pcie_rb_ctrl: directed scenarios plus randomized run against a ring-buffer reference model
module tb_pcie_rb_ctrl;
  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  logic host_enable = 1'b0;
  logic [3:0] host_rd_ptr = '0;
  logic host_rd_ptr_valid = 1'b0;
  logic pcie_rb_update_valid = 1'b0;
  logic [3:0] pcie_rb_update_size = '0;
  logic [3:0] pcie_rb_wr_base_addr;
  logic pcie_rb_almost_full;
  logic disable_pcie;
  logic [3:0] rb_occupancy;
  logic update_err;
  logic [31:0] pdu_cnt;
  int n_checks = 0;
  int n_fail = 0;

  pcie_rb_ctrl #(.PDU_AWIDTH(4), .AF_MARGIN(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .host_enable(host_enable), .host_rd_ptr(host_rd_ptr),
    .host_rd_ptr_valid(host_rd_ptr_valid), .pcie_rb_update_valid(pcie_rb_update_valid),
    .pcie_rb_update_size(pcie_rb_update_size), .pcie_rb_wr_base_addr(pcie_rb_wr_base_addr),
    .pcie_rb_almost_full(pcie_rb_almost_full), .disable_pcie(disable_pcie),
    .rb_occupancy(rb_occupancy), .update_err(update_err), .pdu_cnt(pdu_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic step(input logic en, input logic rdv, input logic [3:0] rdp, input logic uv, input logic [3:0] us);
    @(negedge Clk);
    host_enable = en;
    host_rd_ptr_valid = rdv;
    host_rd_ptr = rdp;
    pcie_rb_update_valid = uv;
    pcie_rb_update_size = us;
    @(posedge Clk);
    #1;
    host_rd_ptr_valid = 1'b0;
    pcie_rb_update_valid = 1'b0;
  endtask

  task automatic test_reset;
    Rst_n = 1'b0;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    Rst_n = 1'b1;
    n_checks++; if (pcie_rb_wr_base_addr !== 4'd0) begin n_fail++; $display("FAIL reset_wr_base: got %0d expected 0", pcie_rb_wr_base_addr); end
    n_checks++; if (rb_occupancy !== 4'd0) begin n_fail++; $display("FAIL reset_occupancy: got %0d expected 0", rb_occupancy); end
    n_checks++; if (disable_pcie !== 1'b1) begin n_fail++; $display("FAIL reset_disable: got %b expected 1", disable_pcie); end
    n_checks++; if (pcie_rb_almost_full !== 1'b1) begin n_fail++; $display("FAIL reset_af: got %b expected 1", pcie_rb_almost_full); end
    n_checks++; if (pdu_cnt !== 32'd0 || update_err !== 1'b0) begin n_fail++; $display("FAIL reset_cnt_err: got cnt=%0d err=%b expected 0/0", pdu_cnt, update_err); end
  endtask

  task automatic test_enable;
    step(1, 0, 0, 0, 0);
    n_checks++; if (disable_pcie !== 1'b0) begin n_fail++; $display("FAIL enable_disable: got %b expected 0", disable_pcie); end
    n_checks++; if (pcie_rb_almost_full !== 1'b0) begin n_fail++; $display("FAIL enable_af: got %b expected 0", pcie_rb_almost_full); end
    n_checks++; if (pcie_rb_wr_base_addr !== 4'd0) begin n_fail++; $display("FAIL enable_wr_base: got %0d expected 0", pcie_rb_wr_base_addr); end
  endtask

  task automatic test_fill;
    step(1, 0, 0, 1, 5);
    step(1, 0, 0, 1, 6);
    n_checks++; if (pcie_rb_wr_base_addr !== 4'd11) begin n_fail++; $display("FAIL fill_wr_base: got %0d expected 11", pcie_rb_wr_base_addr); end
    n_checks++; if (rb_occupancy !== 4'd11) begin n_fail++; $display("FAIL fill_occupancy: got %0d expected 11", rb_occupancy); end
    n_checks++; if (pcie_rb_almost_full !== 1'b0) begin n_fail++; $display("FAIL fill_af_free4: got %b expected 0", pcie_rb_almost_full); end
    step(1, 0, 0, 1, 1);
    n_checks++; if (pcie_rb_almost_full !== 1'b1) begin n_fail++; $display("FAIL fill_af_free3: got %b expected 1", pcie_rb_almost_full); end
    n_checks++; if (pdu_cnt !== 32'd3) begin n_fail++; $display("FAIL fill_cnt: got %0d expected 3", pdu_cnt); end
    step(1, 0, 0, 1, 0);
    n_checks++; if (pcie_rb_wr_base_addr !== 4'd12 || pdu_cnt !== 32'd3 || update_err !== 1'b0) begin n_fail++; $display("FAIL size0_ignored: got wr=%0d cnt=%0d err=%b expected 12/3/0", pcie_rb_wr_base_addr, pdu_cnt, update_err); end
  endtask

  task automatic test_overflow;
    step(1, 0, 0, 1, 4);
    n_checks++; if (update_err !== 1'b1) begin n_fail++; $display("FAIL ovf_err: got %b expected 1", update_err); end
    n_checks++; if (pcie_rb_wr_base_addr !== 4'd12 || pdu_cnt !== 32'd3) begin n_fail++; $display("FAIL ovf_dropped: got wr=%0d cnt=%0d expected 12/3", pcie_rb_wr_base_addr, pdu_cnt); end
    step(1, 1, 10, 0, 0);
    n_checks++; if (rb_occupancy !== 4'd2) begin n_fail++; $display("FAIL rdptr_occupancy: got %0d expected 2", rb_occupancy); end
    n_checks++; if (update_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", update_err); end
  endtask

  task automatic test_wrap;
    step(1, 0, 0, 1, 2);
    step(1, 0, 0, 1, 3);
    n_checks++; if (pcie_rb_wr_base_addr !== 4'd1) begin n_fail++; $display("FAIL wrap_wr_base: got %0d expected 1", pcie_rb_wr_base_addr); end
    n_checks++; if (rb_occupancy !== 4'd7) begin n_fail++; $display("FAIL wrap_occupancy: got %0d expected 7", rb_occupancy); end
    step(1, 1, 1, 1, 2);
    n_checks++; if (pcie_rb_wr_base_addr !== 4'd3 || rb_occupancy !== 4'd2) begin n_fail++; $display("FAIL simul_both: got wr=%0d occ=%0d expected 3/2", pcie_rb_wr_base_addr, rb_occupancy); end
    n_checks++; if (pdu_cnt !== 32'd6) begin n_fail++; $display("FAIL simul_cnt: got %0d expected 6", pdu_cnt); end
  endtask

  task automatic test_drain;
    step(1, 0, 0, 1, 1);
    n_checks++; if (rb_occupancy !== 4'd3) begin n_fail++; $display("FAIL drain_pre_occ: got %0d expected 3", rb_occupancy); end
    step(0, 0, 0, 0, 0);
    n_checks++; if (disable_pcie !== 1'b1 || pcie_rb_almost_full !== 1'b0) begin n_fail++; $display("FAIL drain_entry: got dis=%b af=%b expected 1/0", disable_pcie, pcie_rb_almost_full); end
    step(0, 0, 0, 1, 2);
    n_checks++; if (pcie_rb_wr_base_addr !== 4'd6 || pdu_cnt !== 32'd8) begin n_fail++; $display("FAIL drain_accept: got wr=%0d cnt=%0d expected 6/8", pcie_rb_wr_base_addr, pdu_cnt); end
    step(0, 1, 6, 0, 0);
    n_checks++; if (rb_occupancy !== 4'd0 || pcie_rb_almost_full !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got occ=%0d af=%b expected 0/0", rb_occupancy, pcie_rb_almost_full); end
    step(0, 0, 0, 0, 0);
    n_checks++; if (pcie_rb_almost_full !== 1'b1 || disable_pcie !== 1'b1) begin n_fail++; $display("FAIL drain_disabled: got af=%b dis=%b expected 1/1", pcie_rb_almost_full, disable_pcie); end
  endtask

  task automatic test_reset_midop;
    step(1, 0, 0, 1, 4);
    n_checks++; if (pcie_rb_wr_base_addr !== 4'd10 || disable_pcie !== 1'b0) begin n_fail++; $display("FAIL midop_pre: got wr=%0d dis=%b expected 10/0", pcie_rb_wr_base_addr, disable_pcie); end
    Rst_n = 1'b0;
    step(1, 1, 5, 1, 3);
    Rst_n = 1'b1;
    n_checks++; if (pcie_rb_wr_base_addr !== 4'd0 || rb_occupancy !== 4'd0) begin n_fail++; $display("FAIL midop_ptrs: got wr=%0d occ=%0d expected 0/0", pcie_rb_wr_base_addr, rb_occupancy); end
    n_checks++; if (disable_pcie !== 1'b1 || pcie_rb_almost_full !== 1'b1) begin n_fail++; $display("FAIL midop_flags: got dis=%b af=%b expected 1/1", disable_pcie, pcie_rb_almost_full); end
    n_checks++; if (pdu_cnt !== 32'd0 || update_err !== 1'b0) begin n_fail++; $display("FAIL midop_cnt_err: got cnt=%0d err=%b expected 0/0", pdu_cnt, update_err); end
  endtask

  // Reference model: ring of 16 slots tracked as head/tail integers and an enable mode.
  task automatic test_random;
    int wr, rd, cnt, mode, occ, free;
    bit err, acc, en, rdv, uv;
    int rdp, us;
    wr = 0; rd = 0; cnt = 0; mode = 0; err = 0; en = 0;
    Rst_n = 1'b0;
    step(0, 0, 0, 0, 0);
    Rst_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) en = !en;
      rdv = $urandom_range(0, 3) == 0;
      rdp = (wr - int'($urandom_range(0, 15))) & 15;
      uv = $urandom_range(0, 1) == 1;
      us = $urandom_range(0, 15);
      occ = (wr - rd) & 15;
      free = 15 - occ;
      acc = uv && us != 0 && us <= free;
      if (uv && us > free) err = 1;
      if (mode == 0) mode = en ? 1 : 0;
      else if (mode == 1) mode = en ? 1 : 2;
      else mode = en ? 1 : (occ == 0 && !acc) ? 0 : 2;
      if (acc) begin wr = (wr + us) & 15; cnt++; end
      if (rdv) rd = rdp;
      step(en, rdv, 4'(rdp), uv, 4'(us));
      occ = (wr - rd) & 15;
      n_checks++;
      if (pcie_rb_wr_base_addr !== 4'(wr) || rb_occupancy !== 4'(occ) || pdu_cnt !== 32'(cnt) || update_err !== err ||
          disable_pcie !== (mode != 1) || pcie_rb_almost_full !== ((15 - occ) < 4 || mode == 0)) begin
        n_fail++;
        $display("FAIL random[%0d]: got wr=%0d occ=%0d cnt=%0d err=%b dis=%b af=%b expected wr=%0d occ=%0d cnt=%0d err=%b dis=%b af=%b",
                 i, pcie_rb_wr_base_addr, rb_occupancy, pdu_cnt, update_err, disable_pcie, pcie_rb_almost_full,
                 wr, occ, cnt, err, mode != 1, (15 - occ) < 4 || mode == 0);
      end
    end
  endtask

  initial begin
    test_reset;
    test_enable;
    test_fill;
    test_overflow;
    test_wrap;
    test_drain;
    test_reset_midop;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pcie_rb_ctrl.md
PCIE_RB_CTRL -- requirements
Module: pcie_rb_ctrl

Interface
REQ-001 The block SHALL have parameter PDU_AWIDTH, default 12: ring-buffer address width in flits; ring depth is 2^PDU_AWIDTH and usable capacity is 2^PDU_AWIDTH-1.
REQ-002 The block SHALL have parameter AF_MARGIN, default 64: almost-full asserts when free flits < AF_MARGIN.
REQ-003 Port Clk, input, 1: single clock for all logic.
REQ-004 Port Rst_n, input, 1: reset, synchronous and active-low.
REQ-005 Port host_enable, input, 1: software ring enable, level.
REQ-006 Port host_rd_ptr, input, PDU_AWIDTH: host read pointer in flits.
REQ-007 Port host_rd_ptr_valid, input, 1: loads host_rd_ptr.
REQ-008 Port pcie_rb_update_valid, input, 1: the PDU generator has committed one PDU.
REQ-009 Port pcie_rb_update_size, input, PDU_AWIDTH: committed PDU size in flits.
REQ-010 Port pcie_rb_wr_base_addr, output, PDU_AWIDTH: write base (tail) pointer given to the PDU generator.
REQ-011 Port pcie_rb_almost_full, output, 1: backpressure to the PDU generator.
REQ-012 Port disable_pcie, output, 1: instructs the PDU generator to stop opening new PDUs.
REQ-013 Port rb_occupancy, output, PDU_AWIDTH: flits written but not yet consumed.
REQ-014 Port update_err, output, 1: sticky overflow flag.
REQ-015 Port pdu_cnt, output, 32: accepted-PDU counter.

Function
REQ-016 The block SHALL hold wr_ptr and rd_ptr registers of PDU_AWIDTH bits each; occupancy SHALL equal (wr_ptr - rd_ptr) mod 2^PDU_AWIDTH, and free SHALL equal 2^PDU_AWIDTH-1-occupancy.
REQ-017 pcie_rb_wr_base_addr SHALL equal wr_ptr, and rb_occupancy SHALL equal the occupancy, both driven combinationally from registers.
REQ-018 The FSM SHALL have three states: DISABLED (entered on reset), RUN and DRAIN.
REQ-019 DISABLED -> RUN SHALL occur when host_enable=1; RUN -> DRAIN SHALL occur when host_enable=0; DRAIN -> DISABLED SHALL occur when occupancy==0 and no update is accepted that cycle; DRAIN -> RUN SHALL occur if host_enable returns to 1.
REQ-020 disable_pcie SHALL be 1 in DISABLED and DRAIN and 0 in RUN, decoded from the state register.
REQ-021 The block SHALL accept updates in every state, because a PDU in flight at disable time must still commit.
REQ-022 An update SHALL be accepted when pcie_rb_update_valid=1, size!=0 and size<=free, where free is computed from the current registered pointers; on acceptance wr_ptr<=wr_ptr+size mod 2^PDU_AWIDTH and pdu_cnt<=pdu_cnt+1 (wrapping at 2^32), visible the next cycle.
REQ-023 A size-0 update SHALL be ignored: no pointer change, no count, no error.
REQ-024 A size>free update SHALL be dropped (wr_ptr and pdu_cnt unchanged) and SHALL set update_err, which stays set until reset.
REQ-025 When host_rd_ptr_valid=1 the block SHALL load rd_ptr<=host_rd_ptr the next cycle, in any state.
REQ-026 A simultaneous update and rd_ptr load SHALL both apply; the overflow check SHALL use the pre-load rd_ptr (conservative).
REQ-027 pcie_rb_almost_full SHALL be 1 when free<AF_MARGIN or state==DISABLED, otherwise 0, computed from registers with zero added latency.
REQ-028 Pointer arithmetic SHALL wrap modulo 2^PDU_AWIDTH with no wrap bit; the one-empty-slot convention distinguishes full from empty.

Reset
REQ-029 While Rst_n=0 at a Clk edge, the block SHALL set state=DISABLED, wr_ptr=0, rd_ptr=0, pdu_cnt=0 and update_err=0.
REQ-030 After reset the outputs SHALL be pcie_rb_wr_base_addr=0, rb_occupancy=0, disable_pcie=1 and pcie_rb_almost_full=1.
REQ-031 Reset asserted mid-operation SHALL override every input in that cycle, including an update, a rd_ptr load and host_enable.

Verification (PDU_AWIDTH=4, AF_MARGIN=4)
REQ-032 Bench SHALL check: reset, then host_enable=1 -> next cycle disable_pcie=0 and almost_full=0, with wr_base=0.
REQ-033 Bench SHALL check: updates of size 5 then 6 -> wr_base=11, occupancy=11, free=4, almost_full=0; a further size 1 -> almost_full=1, pdu_cnt=3.
REQ-034 Bench SHALL check: with occupancy=12, an update of size 4 -> dropped, update_err=1, wr_base=12; then rd_ptr=10 -> occupancy=2.
REQ-035 Bench SHALL check: wr_ptr=14, update of size 3 -> wr_base=1 (wrap); rd_ptr load and update in the same cycle -> both applied.
REQ-036 Bench SHALL check: RUN with occupancy=3, host_enable=0 -> DRAIN (disable_pcie=1); a size-2 update is still accepted; rd_ptr set to wr_ptr -> next cycle DISABLED with almost_full=1.
REQ-037 Bench SHALL check: Rst_n=0 during an update -> update discarded, all REQ-030 values present.
